// File: rtl/dfi_resp_pkg.sv
// dfi_resp_pkg: DFI responder command set, error-bit indices and per-phase command decode
package dfi_resp_pkg;
  typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF} cmd_e;
  localparam int ERR_NO_ROW   = 0;
  localparam int ERR_ACT_OPEN = 1;
  localparam int ERR_OVF      = 2;
  localparam int ERR_UNF      = 3;
  function automatic cmd_e dfi_decode(input logic [3:0] c);
    return c[3]               ? CMD_NOP :
           c[2:0] == 3'b011   ? CMD_ACT :
           c[2:0] == 3'b101   ? CMD_RD  :
           c[2:0] == 3'b100   ? CMD_WR  :
           c[2:0] == 3'b010   ? CMD_PRE :
           c[2:0] == 3'b001   ? CMD_REF : CMD_NOP;
  endfunction
endpackage

// File: rtl/dfi_phy_responder_if.sv
// dfi_phy_responder_if: 4-phase DFI command/data bus, master = controller, slave = PHY responder
interface dfi_phy_responder_if #(
  parameter int A_W  = 17,
  parameter int BA_W = 3,
  parameter int D_W  = 32
);
  logic [3:0]         dfi_cs_n;
  logic [3:0]         dfi_ras_n;
  logic [3:0]         dfi_cas_n;
  logic [3:0]         dfi_we_n;
  logic [4*A_W-1:0]   dfi_address;
  logic [4*BA_W-1:0]  dfi_bank;
  logic [4*D_W-1:0]   dfi_wrdata;
  logic [3:0]         dfi_wrdata_en;
  logic [4*D_W/8-1:0] dfi_wrdata_mask;
  logic [3:0]         dfi_rddata_en;
  logic [4*D_W-1:0]   dfi_rddata;
  logic [3:0]         dfi_rddata_valid;
  modport master (
    output dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_address, dfi_bank,
    output dfi_wrdata, dfi_wrdata_en, dfi_wrdata_mask, dfi_rddata_en,
    input  dfi_rddata, dfi_rddata_valid
  );
  modport slave (
    input  dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_address, dfi_bank,
    input  dfi_wrdata, dfi_wrdata_en, dfi_wrdata_mask, dfi_rddata_en,
    output dfi_rddata, dfi_rddata_valid
  );
endinterface

// File: rtl/dfi_resp_addr_fifo.sv
// dfi_resp_addr_fifo: multi-push burst-index FIFO with same-cycle pop bypass and overflow/underflow strobes
module dfi_resp_addr_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  parameter int NP    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NP-1:0]   push,
  input  logic [NP*W-1:0] push_data,
  input  logic            pop,
  output logic [W-1:0]    pop_data,
  output logic            pop_ok,
  output logic            overflow,
  output logic            underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NP-1:0] pend;
  logic          empty;
  assign empty = cnt_q == '0;
  always_comb begin
    mem_d     = mem_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;
    pend      = push;
    pop_data  = '0;
    pop_ok    = 1'b0;
    overflow  = 1'b0;
    if (pop && !empty) begin
      pop_data = mem_q[rp_q];
      pop_ok   = 1'b1;
      rp_d     = rp_q + PW'(1);
      cnt_d    = cnt_q - CW'(1);
    end
    for (int i = 0; i < NP; i++)
      if (pop && empty && pend[i] && !pop_ok) begin
        pop_data = push_data[i*W +: W];
        pop_ok   = 1'b1;
        pend[i]  = 1'b0;
      end
    underflow = pop && !pop_ok;
    for (int i = 0; i < NP; i++)
      if (pend[i]) begin
        if (cnt_d == CW'(DEPTH)) overflow = 1'b1;
        else begin
          mem_d[wp_d] = push_data[i*W +: W];
          wp_d        = wp_d + PW'(1);
          cnt_d       = cnt_d + CW'(1);
        end
      end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/dfi_phy_responder.sv
// dfi_phy_responder: DFI PHY/DRAM responder with bank tracking, burst array, read latency pipe and sticky errors
module dfi_phy_responder
  import dfi_resp_pkg::*;
#(
  parameter int A_W        = 17,
  parameter int BA_W       = 3,
  parameter int D_W        = 32,
  parameter int MEM_AW     = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RD_LAT = 15
) (
  input  logic               clk,
  input  logic               rst,
  dfi_phy_responder_if.slave dfi,
  input  logic [3:0]         rd_lat_cfg,
  input  logic               err_clr,
  output logic [3:0]         err_flags,
  output logic [15:0]        act_count
);
  localparam int NB = 2 ** BA_W;
  localparam int NW = 2 ** MEM_AW;
  localparam int BW = 4 * D_W;
  localparam int MB = D_W / 8;
  localparam int LW = $clog2(MAX_RD_LAT);
  logic [NB-1:0]       open_q, open_d;
  logic [3:0]          err_q, err_d;
  logic [1:0]          cmd_err;
  logic [15:0]         act_q, act_d;
  logic [2:0]          act_inc;
  logic [16:0]         act_sum;
  logic [3:0]          wr_push, rd_push;
  logic [4*MEM_AW-1:0] push_idx;
  cmd_e                cmd;
  logic [BA_W-1:0]     ba;
  logic                wr_pop, rd_pop;
  logic                wr_ok, wr_ovf, wr_unf, rd_ok, rd_ovf, rd_unf;
  logic [MEM_AW-1:0]   wr_idx, rd_idx;
  logic [BW-1:0]       mem_q [NW];
  logic [BW-1:0]       wr_word, rd_word;
  logic [3:0]          lat;
  logic [LW-1:0]       slot;
  logic [BW-1:0]       sd_q [MAX_RD_LAT];
  logic [BW-1:0]       sd_d [MAX_RD_LAT];
  logic [3:0]          sv_q [MAX_RD_LAT];
  logic [3:0]          sv_d [MAX_RD_LAT];
  assign wr_pop               = |dfi.dfi_wrdata_en;
  assign rd_pop               = |dfi.dfi_rddata_en;
  assign dfi.dfi_rddata       = sd_q[0];
  assign dfi.dfi_rddata_valid = sv_q[0];
  assign err_flags            = err_q;
  assign act_count            = act_q;
  always_comb begin
    open_d   = open_q;
    cmd_err  = '0;
    act_inc  = '0;
    wr_push  = '0;
    rd_push  = '0;
    push_idx = '0;
    cmd      = CMD_NOP;
    ba       = '0;
    for (int i = 0; i < 4; i++) begin
      cmd = dfi_decode({dfi.dfi_cs_n[i], dfi.dfi_ras_n[i], dfi.dfi_cas_n[i], dfi.dfi_we_n[i]});
      ba  = dfi.dfi_bank[i*BA_W +: BA_W];
      push_idx[i*MEM_AW +: MEM_AW] = {ba, dfi.dfi_address[i*A_W+3 +: MEM_AW-BA_W]};
      wr_push[i] = cmd == CMD_WR;
      rd_push[i] = cmd == CMD_RD;
      cmd_err[ERR_NO_ROW] = cmd_err[ERR_NO_ROW] | ((cmd == CMD_RD || cmd == CMD_WR) && !open_d[ba])
                          | (cmd == CMD_REF && |open_d);
      cmd_err[ERR_ACT_OPEN] = cmd_err[ERR_ACT_OPEN] | (cmd == CMD_ACT && open_d[ba]);
      act_inc = act_inc + 3'(cmd == CMD_ACT);
      if (cmd == CMD_ACT) open_d[ba] = 1'b1;
      if (cmd == CMD_PRE) begin
        if (dfi.dfi_address[i*A_W+10]) open_d = '0;
        else open_d[ba] = 1'b0;
      end
    end
  end
  always_comb begin
    err_d = err_clr ? 4'b0 : err_q;
    err_d[ERR_NO_ROW]   = err_d[ERR_NO_ROW] | cmd_err[ERR_NO_ROW];
    err_d[ERR_ACT_OPEN] = err_d[ERR_ACT_OPEN] | cmd_err[ERR_ACT_OPEN];
    err_d[ERR_OVF]      = err_d[ERR_OVF] | wr_ovf | rd_ovf;
    err_d[ERR_UNF]      = err_d[ERR_UNF] | wr_unf | rd_unf;
    act_sum = {1'b0, act_q} + {14'b0, act_inc};
    act_d   = act_sum[16] ? 16'hFFFF : act_sum[15:0];
  end
  always_comb begin
    wr_word = mem_q[wr_idx];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < MB; j++)
        if (dfi.dfi_wrdata_en[i] && !dfi.dfi_wrdata_mask[i*MB+j])
          wr_word[i*D_W+j*8 +: 8] = dfi.dfi_wrdata[i*D_W+j*8 +: 8];
    rd_word = wr_ok && wr_idx == rd_idx ? wr_word : mem_q[rd_idx];
    lat  = rd_lat_cfg == 4'd0 ? 4'd1 : rd_lat_cfg > 4'(MAX_RD_LAT) ? 4'(MAX_RD_LAT) : rd_lat_cfg;
    slot = LW'(lat - 4'd1);
    for (int k = 0; k < MAX_RD_LAT - 1; k++) begin
      sd_d[k] = sd_q[k+1];
      sv_d[k] = sv_q[k+1];
    end
    sd_d[MAX_RD_LAT-1] = '0;
    sv_d[MAX_RD_LAT-1] = '0;
    if (rd_pop) begin
      sd_d[slot] = rd_ok ? rd_word : '0;
      sv_d[slot] = rd_ok ? dfi.dfi_rddata_en : 4'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      open_q <= '0;
      err_q  <= '0;
      act_q  <= '0;
      for (int k = 0; k < MAX_RD_LAT; k++) begin
        sd_q[k] <= '0;
        sv_q[k] <= '0;
      end
    end else begin
      open_q <= open_d;
      err_q  <= err_d;
      act_q  <= act_d;
      sd_q   <= sd_d;
      sv_q   <= sv_d;
    end
  end
  always_ff @(posedge clk) if (wr_ok) mem_q[wr_idx] <= wr_word;
  dfi_resp_addr_fifo #(.W(MEM_AW), .DEPTH(FIFO_DEPTH), .NP(4)) u_wr_fifo (
    .clk(clk), .rst(rst), .push(wr_push), .push_data(push_idx), .pop(wr_pop),
    .pop_data(wr_idx), .pop_ok(wr_ok), .overflow(wr_ovf), .underflow(wr_unf)
  );
  dfi_resp_addr_fifo #(.W(MEM_AW), .DEPTH(FIFO_DEPTH), .NP(4)) u_rd_fifo (
    .clk(clk), .rst(rst), .push(rd_push), .push_data(push_idx), .pop(rd_pop),
    .pop_data(rd_idx), .pop_ok(rd_ok), .overflow(rd_ovf), .underflow(rd_unf)
  );
endmodule
